sqrt_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one multi-cycle sqrt core between NREQ requesters in the calculator datapath.
- Latches the winning operand and issues a one-cycle start pulse to the core.
- Waits for the core's done, then returns the result to the winning requester.
- Includes a watchdog so a stalled core cannot hang the calculator.

---
 rtl/sqrt_share_arb.sv | 168 ++++++++++++++++
 tb/tb_sqrt_share_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_share_arb.sv
// Round-robin arbiter/sequencer sharing one multi-cycle sqrt core among NREQ requesters.
// Optional one-entry result cache enabled by defining SQRT_ARB_CACHE_EN.
module sqrt_share_arb #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   operand,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [W-1:0]        rsp_data,
    output logic                err,
    output logic                busy,
    output logic                core_start,
    output logic [W-1:0]        core_A,
    input  logic [W-1:0]        core_result,
    input  logic                core_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [PW-1:0]   win_c;
    logic [PW-1:0]   ptr_nxt;
    logic            found;
    logic [W-1:0]    op_c;
    logic [15:0]     cnt;
    logic [NREQ-1:0] win_oh;
    logic [NREQ-1:0] win_c_oh;

`ifdef SQRT_ARB_CACHE_EN
    logic            cache_vld;
    logic [W-1:0]    cache_op;
    logic [W-1:0]    cache_res;
    logic            hit_pend;
`endif

    // Round-robin search starting at ptr; first set request bit wins.
    always_comb begin
        int unsigned j;
        j        = 0;
        found    = 1'b0;
        win_c    = '0;
        op_c     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = (32'(ptr) + i) % NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                win_c = PW'(j);
                op_c  = operand[j*W +: W];
            end
        end
    end

    assign ptr_nxt  = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    assign win_oh   = NREQ'(1) << win;
    assign win_c_oh = NREQ'(1) << win_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            win        <= '0;
            cnt        <= '0;
            gnt        <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            core_start <= 1'b0;
            core_A     <= '0;
`ifdef SQRT_ARB_CACHE_EN
            cache_vld  <= 1'b0;
            cache_op   <= '0;
            cache_res  <= '0;
            hit_pend   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    gnt        <= '0;
                    rsp_valid  <= '0;
                    err        <= 1'b0;
                    core_start <= 1'b0;
                    if (found) begin
                        win  <= win_c;
                        gnt  <= win_c_oh;
                        busy <= 1'b1;
`ifdef SQRT_ARB_CACHE_EN
                        // Cache hit skips the core; RESP emits rsp_valid on its first edge.
                        if (cache_vld && op_c == cache_op) begin
                            rsp_data <= cache_res;
                            hit_pend <= 1'b1;
                            state    <= RESP;
                        end else begin
                            core_A     <= op_c;
                            core_start <= 1'b1;
                            state      <= START;
                        end
`else
                        core_A     <= op_c;
                        core_start <= 1'b1;
                        state      <= START;
`endif
                    end
                end
                START: begin
                    gnt        <= '0;
                    core_start <= 1'b0;
                    cnt        <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        rsp_data  <= core_result;
                        rsp_valid <= win_oh;
                        state     <= RESP;
`ifdef SQRT_ARB_CACHE_EN
                        cache_vld <= 1'b1;
                        cache_op  <= core_A;
                        cache_res <= core_result;
`endif
                    end else if (cnt == 16'(TIMEOUT - 1)) begin
                        rsp_data  <= '1;
                        rsp_valid <= win_oh;
                        err       <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
`ifdef SQRT_ARB_CACHE_EN
                    if (hit_pend) begin
                        gnt       <= '0;
                        rsp_valid <= win_oh;
                        hit_pend  <= 1'b0;
                    end else begin
                        rsp_valid <= '0;
                        err       <= 1'b0;
                        ptr       <= ptr_nxt;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
`else
                    rsp_valid <= '0;
                    err       <= 1'b0;
                    ptr       <= ptr_nxt;
                    busy      <= 1'b0;
                    state     <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_share_arb.sv
// Directed self-checking bench for sqrt_share_arb with a 17-cycle floor-sqrt core model.
module tb_sqrt_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int TO   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] operand = '0;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        err;
    logic        busy;
    logic        core_start;
    logic [15:0] core_A;
    logic [15:0] core_result;
    logic        core_done;

    logic        run = 1'b0;
    logic [4:0]  c = '0;
    logic        mdone = 1'b0;
    logic [15:0] mres = '0;
    logic        core_en = 1'b1;
    logic        inject = 1'b0;

    int checks = 0;
    int errors = 0;

    sqrt_share_arb #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .operand(operand),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err),
        .busy(busy), .core_start(core_start), .core_A(core_A),
        .core_result(core_result), .core_done(core_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] isqrt(input logic [15:0] v);
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= 32'(v)) r++;
        return 16'(r);
    endfunction

    // Core model: done pulses 17 cycles after the cycle in which core_start is high.
    always @(posedge clk) begin
        if (rst) begin
            run   <= 1'b0;
            c     <= '0;
            mdone <= 1'b0;
        end else begin
            mdone <= 1'b0;
            if (core_start && !run) begin
                run <= 1'b1;
                c   <= 5'd1;
            end else if (run) begin
                if (c == 5'd16) begin
                    mdone <= core_en;
                    run   <= 1'b0;
                    mres  <= isqrt(core_A);
                end else begin
                    c <= c + 1'b1;
                end
            end
        end
    end

    assign core_done   = mdone | inject;
    assign core_result = mres;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({gnt, rsp_valid, err, busy, core_start} !== 11'b0) begin
            errors++;
            $display("FAIL reset_ctrl got gnt=%b rsp_valid=%b err=%b busy=%b start=%b want all 0",
                     gnt, rsp_valid, err, busy, core_start);
        end
        checks++;
        if (rsp_data !== 16'h0000 || core_A !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data got rsp_data=%h core_A=%h want 0000 0000", rsp_data, core_A);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single;
        int early = 0;
        operand[15:0] = 16'h00E1;
        req = 4'b0001;
        step();
        checks++;
        if (gnt !== 4'b0001 || core_start !== 1'b1 || core_A !== 16'h00E1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt got gnt=%b start=%b core_A=%h busy=%b want 0001 1 00e1 1",
                     gnt, core_start, core_A, busy);
        end
        req = 4'b0000;
        for (int k = 1; k <= 17; k++) begin
            step();
            if (rsp_valid !== 4'b0000) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL single_early got %0d early responses want 0", early);
        end
        step();
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 16'h000F || err !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp got valid=%b data=%h err=%b want 0001 000f 0",
                     rsp_valid, rsp_data, err);
        end
        step();
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_data !== 16'h000F) begin
            errors++;
            $display("FAIL single_idle got valid=%b busy=%b data=%h want 0000 0 000f",
                     rsp_valid, busy, rsp_data);
        end
    endtask

    task automatic test_simultaneous;
        operand[31:16] = 16'h0190;
        operand[63:48] = 16'h0051;
        req = 4'b1010;
        step();
        checks++;
        if (gnt !== 4'b0010 || core_A !== 16'h0190) begin
            errors++;
            $display("FAIL simul_gnt1 got gnt=%b core_A=%h want 0010 0190", gnt, core_A);
        end
        req = 4'b1000;
        for (int k = 0; k < 40 && rsp_valid == 4'b0000; k++) step();
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 16'h0014) begin
            errors++;
            $display("FAIL simul_rsp1 got valid=%b data=%h want 0010 0014", rsp_valid, rsp_data);
        end
        for (int k = 0; k < 10 && gnt == 4'b0000; k++) step();
        checks++;
        if (gnt !== 4'b1000 || core_A !== 16'h0051) begin
            errors++;
            $display("FAIL simul_gnt2 got gnt=%b core_A=%h want 1000 0051", gnt, core_A);
        end
        req = 4'b0000;
        for (int k = 0; k < 40 && rsp_valid == 4'b0000; k++) step();
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_data !== 16'h0009) begin
            errors++;
            $display("FAIL simul_rsp2 got valid=%b data=%h want 1000 0009", rsp_valid, rsp_data);
        end
        for (int k = 0; k < 10 && busy !== 1'b0; k++) step();
    endtask

    task automatic test_fairness;
        logic [1:0]  order [5];
        logic [15:0] want  [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        want  = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0002};
        operand = {16'h0019, 16'h0010, 16'h0009, 16'h0004};
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 60 && gnt == 4'b0000; k++) step();
            checks++;
            if (gnt !== (4'b0001 << order[g])) begin
                errors++;
                $display("FAIL fair_gnt%0d got %b want %b", g, gnt, 4'b0001 << order[g]);
            end
            if (g == 4) req = 4'b0000;
            for (int k = 0; k < 40 && rsp_valid == 4'b0000; k++) step();
            checks++;
            if (rsp_data !== want[g] || rsp_valid !== (4'b0001 << order[g])) begin
                errors++;
                $display("FAIL fair_rsp%0d got valid=%b data=%h want %b %h",
                         g, rsp_valid, rsp_data, 4'b0001 << order[g], want[g]);
            end
        end
        for (int k = 0; k < 10 && busy !== 1'b0; k++) step();
    endtask

    task automatic test_timeout;
        int early = 0;
        core_en = 1'b0;
        operand[47:32] = 16'h0010;
        req = 4'b0100;
        step();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL to_gnt got %b want 0100", gnt);
        end
        req = 4'b0000;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (rsp_valid !== 4'b0000 || err !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL to_early got %0d early responses want 0", early);
        end
        step();
        checks++;
        if (rsp_valid !== 4'b0100 || err !== 1'b1 || rsp_data !== 16'hFFFF) begin
            errors++;
            $display("FAIL to_rsp got valid=%b err=%b data=%h want 0100 1 ffff",
                     rsp_valid, err, rsp_data);
        end
        step();
        checks++;
        if (rsp_valid !== 4'b0000 || err !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse got valid=%b err=%b want 0000 0", rsp_valid, err);
        end
        step();
        inject = 1'b1;
        step();
        inject = 1'b0;
        step();
        step();
        checks++;
        if (rsp_valid !== 4'b0000 || err !== 1'b0 || busy !== 1'b0 || rsp_data !== 16'hFFFF) begin
            errors++;
            $display("FAIL to_stale_done got valid=%b err=%b busy=%b data=%h want 0000 0 0 ffff",
                     rsp_valid, err, busy, rsp_data);
        end
        core_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        int stray = 0;
        operand[15:0] = 16'h0100;
        req = 4'b0001;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rmid_gnt got %b want 0001", gnt);
        end
        req = 4'b0000;
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000 || gnt !== 4'b0000 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL rmid_state got busy=%b valid=%b gnt=%b start=%b want 0 0000 0000 0",
                     busy, rsp_valid, gnt, core_start);
        end
        for (int k = 0; k < 30; k++) begin
            step();
            if (rsp_valid !== 4'b0000 || err !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rmid_stray got %0d stray responses want 0", stray);
        end
        operand[47:32] = 16'h0031;
        operand[63:48] = 16'h0001;
        req = 4'b1100;
        step();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL rmid_ptr got gnt=%b want 0100", gnt);
        end
        req = 4'b1000;
        for (int k = 0; k < 40 && rsp_valid == 4'b0000; k++) step();
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_data !== 16'h0007) begin
            errors++;
            $display("FAIL rmid_rsp2 got valid=%b data=%h want 0100 0007", rsp_valid, rsp_data);
        end
        for (int k = 0; k < 10 && gnt == 4'b0000; k++) step();
        req = 4'b0000;
        for (int k = 0; k < 40 && rsp_valid == 4'b0000; k++) step();
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_data !== 16'h0001) begin
            errors++;
            $display("FAIL rmid_rsp3 got valid=%b data=%h want 1000 0001", rsp_valid, rsp_data);
        end
        for (int k = 0; k < 10 && busy !== 1'b0; k++) step();
    endtask

`ifdef SQRT_ARB_CACHE_EN
    task automatic test_cache;
        operand[15:0] = 16'h00E1;
        req = 4'b0001;
        step();
        checks++;
        if (gnt !== 4'b0001 || core_start !== 1'b1) begin
            errors++;
            $display("FAIL cache_miss got gnt=%b start=%b want 0001 1", gnt, core_start);
        end
        for (int k = 0; k < 40 && rsp_valid == 4'b0000; k++) step();
        checks++;
        if (rsp_data !== 16'h000F) begin
            errors++;
            $display("FAIL cache_rsp1 got %h want 000f", rsp_data);
        end
        for (int k = 0; k < 10 && gnt == 4'b0000; k++) step();
        checks++;
        if (gnt !== 4'b0001 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL cache_hit got gnt=%b start=%b want 0001 0", gnt, core_start);
        end
        req = 4'b0000;
        step();
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 16'h000F || err !== 1'b0) begin
            errors++;
            $display("FAIL cache_rsp2 got valid=%b data=%h err=%b want 0001 000f 0",
                     rsp_valid, rsp_data, err);
        end
        for (int k = 0; k < 10 && busy !== 1'b0; k++) step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_reset_mid();
`ifdef SQRT_ARB_CACHE_EN
        test_cache();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
